// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      ON    = 2'd2
   } state_t;

   localparam logic [7:0] SEG_BLANK_AL = 8'hFF;
   localparam logic [7:0] SEG_BLANK_AH = 8'h00;
   localparam int         MAX_DIGITS   = 16;

   // Ceiling log2 for elaboration-time width calculations.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/seg_sel_encoder.sv
// Digit index to binary or one-hot select, with output polarity and deselect.
// Latency: combinational.
// Backpressure: none; active=0 forces the all-inactive deselect value.
module seg_sel_encoder
   import seg_scan_pkg::*;
#(
   parameter int DIGITS         = 8,
   parameter int SEL_ONEHOT     = 0,
   parameter int SEL_ACTIVE_LOW = 0,
   localparam int SEL_W         = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS),
   localparam int SEL_OUT_W     = (SEL_ONEHOT != 0) ? DIGITS : SEL_W
)(
   input  logic [3:0]           idx,
   input  logic                 active,
   output logic [SEL_OUT_W-1:0] sel
);

   logic [SEL_OUT_W-1:0] raw;

   generate
      if (SEL_ONEHOT != 0) begin : g_onehot
         // One bit per digit; nothing set while deselected.
         always_comb begin
            raw = '0;
            for (int i = 0; i < SEL_OUT_W; i++) begin
               raw[i] = active && (idx == 4'(i));
            end
         end
      end else begin : g_binary
         assign raw = active ? SEL_OUT_W'(idx) : '0;
      end
   endgenerate

   assign sel = (SEL_ACTIVE_LOW != 0) ? ~raw : raw;

endmodule

// File: rtl/seg_scan_pwm.sv
// Multiplexed 7-segment scanner with per-digit mask, PWM brightness and guard band.
// Latency: all outputs registered; first slot appears one cycle after en is sampled high.
// Backpressure: none; en=0 returns to idle outputs on the next cycle.
module seg_scan_pwm
   import seg_scan_pkg::*;
#(
   parameter int CLK_FREQ       = 24_000_000,
   parameter int SCAN_FREQ      = 200,
   parameter int DIGITS         = 8,
   parameter int SEL_ONEHOT     = 0,
   parameter int SEL_ACTIVE_LOW = 0,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int GUARD_CYCLES   = 24,
   localparam int SEL_W         = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS),
   localparam int SEL_OUT_W     = (SEL_ONEHOT != 0) ? DIGITS : SEL_W
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [3:0]            bright,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic [8*DIGITS-1:0]   seg_data_in,
   output logic [SEL_OUT_W-1:0]  seg_sel,
   output logic [7:0]            seg_data,
   output logic [3:0]            cur_digit,
   output logic                  frame_start
);

   localparam int SLOT  = CLK_FREQ / (SCAN_FREQ * ((DIGITS < 1) ? 1 : DIGITS));
   localparam int TICK  = (SLOT - GUARD_CYCLES) / 16;
   localparam int CNT_W = (clog2(SLOT + 1) < 1) ? 1 : clog2(SLOT + 1);

   localparam logic [CNT_W-1:0]     SLOT_LAST = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0]     GUARD_END = CNT_W'(GUARD_CYCLES);
   localparam logic [3:0]           DIG_LAST  = 4'(DIGITS - 1);
   localparam logic [7:0]           BLANK     = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK_AL : SEG_BLANK_AH;
   localparam logic [SEL_OUT_W-1:0] SEL_IDLE  = (SEL_ACTIVE_LOW != 0) ? {SEL_OUT_W{1'b1}} : '0;

   generate
      if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
         $error("seg_scan_pwm: DIGITS must be within 1..16");
      end
      if (SLOT < GUARD_CYCLES + 16) begin : g_bad_slot
         $error("seg_scan_pwm: slot too short for guard band plus 16 PWM ticks");
      end
   endgenerate

   // Pad per-digit inputs to 16 entries so a 4-bit digit index is always in range.
   logic [7:0]            code_ext [MAX_DIGITS];
   logic [MAX_DIGITS-1:0] den_ext;

   generate
      for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_ext
         if (g < DIGITS) begin : g_real
            assign code_ext[g] = seg_data_in[8*g +: 8];
            assign den_ext[g]  = digit_en[g];
         end else begin : g_pad
            assign code_ext[g] = BLANK;
            assign den_ext[g]  = 1'b0;
         end
      end
   endgenerate

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           dig_q, dig_d;
   logic [7:0]           code_l_q, code_l_d;
   logic [3:0]           bright_l_q, bright_l_d;
   logic                 den_l_q, den_l_d;
   logic [SEL_OUT_W-1:0] seg_sel_q, seg_sel_d;
   logic [7:0]           seg_data_q, seg_data_d;
   logic [3:0]           cur_digit_q, cur_digit_d;
   logic                 frame_start_q, frame_start_d;

   logic                 new_slot;
   logic [CNT_W-1:0]     lit_lim;
   logic [CNT_W-1:0]     pwm_pos;

   seg_sel_encoder #(
      .DIGITS         (DIGITS),
      .SEL_ONEHOT     (SEL_ONEHOT),
      .SEL_ACTIVE_LOW (SEL_ACTIVE_LOW)
   ) u_sel_enc (
      .idx    (dig_d),
      .active (en),
      .sel    (seg_sel_d)
   );

   // Next-state for the slot/digit counters, slot-start sampling and the output image.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      dig_d         = dig_q;
      code_l_d      = code_l_q;
      bright_l_d    = bright_l_q;
      den_l_d       = den_l_q;
      new_slot      = 1'b0;
      seg_data_d    = BLANK;
      frame_start_d = 1'b0;
      lit_lim       = '0;
      pwm_pos       = '0;

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
         dig_d   = '0;
      end else if (state_q == IDLE) begin
         new_slot = 1'b1;
         cnt_d    = '0;
         dig_d    = '0;
      end else if (cnt_q == SLOT_LAST) begin
         new_slot = 1'b1;
         cnt_d    = '0;
         dig_d    = (dig_q == DIG_LAST) ? 4'd0 : dig_q + 4'd1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Inputs are captured once per slot so mid-slot changes never glitch the display.
      if (new_slot) begin
         code_l_d   = code_ext[dig_d];
         bright_l_d = bright;
         den_l_d    = den_ext[dig_d];
      end

      if (en) begin
         state_d = (cnt_d < GUARD_END) ? GUARD : ON;
      end

      lit_lim = CNT_W'((int'(bright_l_d) + 1) * TICK);
      pwm_pos = cnt_d - GUARD_END;
      if (en && state_d == ON && den_l_d && pwm_pos < lit_lim) begin
         seg_data_d = code_l_d;
      end

      frame_start_d = new_slot && (dig_d == 4'd0);
      cur_digit_d   = dig_d;
   end

   // State and output registers; reset drives the idle image immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         dig_q         <= '0;
         code_l_q      <= BLANK;
         bright_l_q    <= '0;
         den_l_q       <= 1'b0;
         seg_sel_q     <= SEL_IDLE;
         seg_data_q    <= BLANK;
         cur_digit_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dig_q         <= dig_d;
         code_l_q      <= code_l_d;
         bright_l_q    <= bright_l_d;
         den_l_q       <= den_l_d;
         seg_sel_q     <= seg_sel_d;
         seg_data_q    <= seg_data_d;
         cur_digit_q   <= cur_digit_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg_sel     = seg_sel_q;
   assign seg_data    = seg_data_q;
   assign cur_digit   = cur_digit_q;
   assign frame_start = frame_start_q;

endmodule

// File: doc/seg_scan_pwm.md
Name: seg_scan_pwm

Overview:
Parametrised multiplexed 7-segment scan driver for 1..16 digits. It is the successor to the fixed 8-digit binary-select scanner. Adds:
- per-digit enable mask
- 16-level PWM brightness
- anti-ghosting guard band
- one-hot or binary select with selectable polarities
- frame-start strobe

It sits between the segment decoders and the display pins.

Parameters:
CLK_FREQ, 24_000_000, system clock in Hz
SCAN_FREQ, 200, full-frame refresh rate in Hz
DIGITS, 8, digit count, legal range 1..16
SEL_ONEHOT, 0, 0 = binary select of width SEL_W = max(1, clog2(DIGITS)); 1 = one-hot select of width DIGITS
SEL_ACTIVE_LOW, 0, 1 = invert every seg_sel bit at the output
SEG_ACTIVE_LOW, 1, 1 = segment on is 0, so blank = 8'hFF; 0 = blank is 8'h00
GUARD_CYCLES, 24, blank cycles at the start of each digit slot

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable
bright  in  4  brightness; 0 = 1/16 duty, 15 = full duty
digit_en  in  DIGITS  per-digit display enable
seg_data_in  in  8*DIGITS  segment codes; digit d occupies bits [8d+7:8d]
seg_sel  out  SEL_OUT_W  digit select; SEL_OUT_W = DIGITS if SEL_ONEHOT, else SEL_W
seg_data  out  8  segment code for the selected digit
cur_digit  out  4  index of the digit being driven
frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot

Behaviour:
- Derived constants:
  - SLOT = CLK_FREQ/(SCAN_FREQ*DIGITS)
  - TICK = (SLOT-GUARD_CYCLES)/16, integer floor
  - Elaboration error if DIGITS is outside 1..16 or SLOT < GUARD_CYCLES+16.
- Outputs are registered. All timing below is as seen at the outputs.
- Reset and idle outputs, applied while rst=1 and whenever en=0:
  - seg_data = blank; frame_start = 0; cur_digit = 0
  - seg_sel = deselect value: binary 0 or one-hot all-inactive, then the polarity parameter is applied
  - slot counter and digit counter cleared
- State machine: IDLE, GUARD, ON.
  - IDLE -> GUARD for digit 0 on the first clock edge that samples en=1. frame_start pulses in that first GUARD cycle.
  - GUARD lasts GUARD_CYCLES cycles, slot cycles 0..GUARD_CYCLES-1:
    - seg_sel = new digit's select; seg_data = blank
  - ON lasts slot cycles GUARD_CYCLES..SLOT-1, with p = cycle-GUARD_CYCLES:
    - seg_data = latched code when p < (bright_l+1)*TICK and digit_en_l = 1; otherwise blank
    - bright=15 gives 16*TICK lit cycles; any remainder cycles of ON stay blank
  - ON -> GUARD for the next digit after slot cycle SLOT-1. The digit index wraps DIGITS-1 -> 0, and frame_start pulses at each wrap.
- Sampling at slot start: seg_data_in[d], bright and digit_en[d] are sampled on the first GUARD cycle of slot d and held for the whole slot. Input changes mid-slot take effect from that digit's next slot. No glitching.
- Masked digit (digit_en[d]=0): its slot still elapses with its select driven and segments blank. Scan timing is independent of the mask. All digits masked: scanning continues, all blank.
- DIGITS=1: the slot repeats every frame, and frame_start pulses every slot.
- en deasserted mid-slot: the next cycle shows idle outputs. Re-enable restarts at digit 0, slot cycle 0.
- rst asserted mid-operation: outputs go to their reset values asynchronously.
- cur_digit tracks seg_sel in every cycle and is zero-extended.

Decomposition:
- Package seg_scan_pkg holds:
  - state enum {IDLE, GUARD, ON}
  - clog2 function
  - SEG_BLANK_AL = 8'hFF and SEG_BLANK_AH = 8'h00
  - MAX_DIGITS = 16
- One sub-module, seg_sel_encoder: combinational digit index -> binary/one-hot select with polarity and deselect handling. Parameters: DIGITS, SEL_ONEHOT, SEL_ACTIVE_LOW.

Test Plan:
Test parameters: CLK_FREQ=8000, SCAN_FREQ=50, DIGITS=4, GUARD_CYCLES=8, giving SLOT=40 and TICK=2.
1. Reset with rst=1, then release with en=1, bright=15, all digits enabled, codes 8'hC0/F9/A4/B0 -> seg_data=FF for 8 cycles then C0 for 32 cycles at seg_sel=0, then the sequence repeats for sel 1..3; frame_start pulses every 160 cycles.
2. bright=3 -> each slot shows 8 blank, 8 lit, 24 blank; bright=0 -> 2 lit cycles per slot.
3. digit_en=4'b0101 -> slots 1 and 3 are fully blank (FF) with seg_sel still at 1 and 3; the period stays 160 cycles.
4. Change seg_data_in[0] from C0 to 99 at cycle 20 of slot 0 -> C0 is held to the end of the slot; 99 appears on the next frame.
5. Drop en at cycle 15 of slot 2 -> the next cycle shows FF and deselected seg_sel; re-enable -> slot 0 restarts and frame_start pulses.
6. SEL_ONEHOT=1, SEL_ACTIVE_LOW=1 -> seg_sel steps through 1110, 1101, 1011, 0111; idle value is 1111; rst asserted mid-slot blanks asynchronously.
